alien_march_sequencer: RTL and testbench

Generates the fleet's march commands for the alien motion/collision block: emits single-cycle LEFT / RIGHT / DOWN pulses on `motion` at a rate that rises as aliens are killed, reverses direction at the screen edges through a multi-pulse descent, and halts permanently on victory or defeat. It sits between the game-control logic (`enable`) and the alien block, consuming that block's `canLeft`, `canRight`, `victory`, `defeat` and `alive` outputs.

---
 rtl/space_invaders_pkg.sv | 21 ++
 rtl/alive_popcount.sv | 18 +
 rtl/alien_march_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alien_march_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared encodings and constants for the space-invaders alien blocks.
package space_invaders_pkg;

  localparam logic [2:0] MOTION_NONE  = 3'd0;
  localparam logic [2:0] MOTION_LEFT  = 3'd1;
  localparam logic [2:0] MOTION_RIGHT = 3'd2;
  localparam logic [2:0] MOTION_DOWN  = 3'd3;

  localparam int NB_LIN = 4;
  localparam int NB_COL = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH_R = 3'd1,
    ST_DESC_R  = 3'd2,
    ST_MARCH_L = 3'd3,
    ST_DESC_L  = 3'd4,
    ST_HALT    = 3'd5
  } march_state_e;

endpackage

// File: rtl/alive_popcount.sv
// Combinational count of set bits in the alien alive mask.
module alive_popcount #(
  parameter int NB_ALIENS = 32,
  parameter int CW        = $clog2(NB_ALIENS + 1)
) (
  input  logic [NB_ALIENS-1:0] alive_i,
  output logic [CW-1:0]        count_o
);

  // Ripple sum of the alive bits
  always_comb begin
    count_o = '0;
    for (int i = 0; i < NB_ALIENS; i++) begin
      count_o = count_o + CW'(alive_i[i]);
    end
  end

endmodule

// File: rtl/alien_march_sequencer.sv
// Fleet march command generator: timed LEFT/RIGHT steps, edge descents, sticky halt.
module alien_march_sequencer
  import space_invaders_pkg::*;
#(
  parameter int TICK_BASE      = 2_000_000,
  parameter int TICK_MIN       = 250_000,
  parameter int TICK_STEP      = 50_000,
  parameter int DESC_GAP       = 16,
  parameter int DESCEND_PULSES = 10,
  parameter int NB_ALIENS      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 canLeft,
  input  logic                 canRight,
  input  logic                 victory,
  input  logic                 defeat,
  input  logic [NB_ALIENS-1:0] alive,
  output logic [2:0]           motion,
  output logic                 anim_frame,
  output logic                 halted
);

  localparam int CW = $clog2(NB_ALIENS + 1);
  localparam int DW = $clog2(DESCEND_PULSES + 1);
  localparam logic [23:0]   GAP_RELOAD = 24'(DESC_GAP - 1);
  localparam logic [DW-1:0] DESC_LAST  = DW'(DESCEND_PULSES - 1);
  localparam logic [DW-1:0] DESC_ONE   = DW'(1);
  localparam logic [23:0]   BASE_24    = 24'(TICK_BASE);
  localparam logic [23:0]   MIN_24     = 24'(TICK_MIN);

  march_state_e  state_q;
  logic [23:0]   tick_cnt_q;
  logic [DW-1:0] desc_cnt_q;
  logic [2:0]    motion_q;
  logic          anim_q;
  logic          halted_q;

  logic [CW-1:0] alive_cnt_s;
  logic [CW-1:0] dead_s;
  logic [31:0]   prod_s;
  logic [23:0]   sub_s;
  logic [23:0]   period_s;
  logic [23:0]   reload_s;

  logic          edge_ok_s;
  march_state_e  opp_march_s;
  march_state_e  desc_state_s;
  logic [2:0]    dir_motion_s;

  alive_popcount #(
    .NB_ALIENS (NB_ALIENS),
    .CW        (CW)
  ) u_popcount (
    .alive_i (alive),
    .count_o (alive_cnt_s)
  );

  // Step period: base minus per-casualty speedup, saturated at 0, floored at TICK_MIN
  always_comb begin
    dead_s = CW'(NB_ALIENS) - alive_cnt_s;
    prod_s = 32'(dead_s) * 32'(TICK_STEP);
    if (prod_s >= 32'(TICK_BASE)) begin
      sub_s = 24'd0;
    end else begin
      sub_s = BASE_24 - prod_s[23:0];
    end
    if (sub_s < MIN_24) begin
      period_s = MIN_24;
    end else begin
      period_s = sub_s;
    end
    reload_s = period_s - 24'd1;
  end

  // Direction-dependent view of the current state
  always_comb begin
    edge_ok_s    = 1'b0;
    opp_march_s  = ST_MARCH_R;
    desc_state_s = ST_DESC_R;
    dir_motion_s = MOTION_NONE;
    case (state_q)
      ST_MARCH_R, ST_DESC_R: begin
        edge_ok_s    = canRight;
        opp_march_s  = ST_MARCH_L;
        desc_state_s = ST_DESC_R;
        dir_motion_s = MOTION_RIGHT;
      end
      ST_MARCH_L, ST_DESC_L: begin
        edge_ok_s    = canLeft;
        opp_march_s  = ST_MARCH_R;
        desc_state_s = ST_DESC_L;
        dir_motion_s = MOTION_LEFT;
      end
      default: begin
        edge_ok_s    = 1'b0;
        opp_march_s  = ST_MARCH_R;
        desc_state_s = ST_DESC_R;
        dir_motion_s = MOTION_NONE;
      end
    endcase
  end

  // March FSM with registered pulse, animation and halt outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 24'd0;
      desc_cnt_q <= '0;
      motion_q   <= MOTION_NONE;
      anim_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      motion_q <= MOTION_NONE;
      // End of game beats any coincident tick
      if ((state_q != ST_IDLE) && (victory || defeat)) begin
        state_q  <= ST_HALT;
        halted_q <= 1'b1;
      end else if (enable) begin
        case (state_q)
          ST_IDLE: begin
            tick_cnt_q <= reload_s;
            state_q    <= ST_MARCH_R;
          end
          ST_MARCH_R, ST_MARCH_L: begin
            if (tick_cnt_q != 24'd0) begin
              tick_cnt_q <= tick_cnt_q - 24'd1;
            end else if (edge_ok_s) begin
              motion_q   <= dir_motion_s;
              anim_q     <= ~anim_q;
              tick_cnt_q <= reload_s;
            end else begin
              motion_q   <= MOTION_DOWN;
              desc_cnt_q <= DESC_LAST;
              if (DESC_LAST == '0) begin
                state_q    <= opp_march_s;
                tick_cnt_q <= reload_s;
              end else begin
                state_q    <= desc_state_s;
                tick_cnt_q <= GAP_RELOAD;
              end
            end
          end
          ST_DESC_R, ST_DESC_L: begin
            if (tick_cnt_q != 24'd0) begin
              tick_cnt_q <= tick_cnt_q - 24'd1;
            end else begin
              motion_q   <= MOTION_DOWN;
              desc_cnt_q <= desc_cnt_q - DESC_ONE;
              if (desc_cnt_q <= DESC_ONE) begin
                state_q    <= opp_march_s;
                tick_cnt_q <= reload_s;
              end else begin
                tick_cnt_q <= GAP_RELOAD;
              end
            end
          end
          ST_HALT: begin
            halted_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign motion     = motion_q;
  assign anim_frame = anim_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_alien_march_sequencer.sv
// Directed, table-driven bench for alien_march_sequencer with small periods.
module tb_alien_march_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        can_left;
  logic        can_right;
  logic        victory;
  logic        defeat;
  logic [31:0] alive;
  logic [2:0]  motion;
  logic        anim_frame;
  logic        halted;

  int total = 0;
  int bad   = 0;

  alien_march_sequencer #(
    .TICK_BASE      (20),
    .TICK_MIN       (8),
    .TICK_STEP      (2),
    .DESC_GAP       (4),
    .DESCEND_PULSES (3),
    .NB_ALIENS      (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .canLeft    (can_left),
    .canRight   (can_right),
    .victory    (victory),
    .defeat     (defeat),
    .alive      (alive),
    .motion     (motion),
    .anim_frame (anim_frame),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        can_l;
    logic        can_r;
    logic [31:0] alv;
    int          gap;
    logic [2:0]  mot;
    logic        anim;
  } vec_t;

  vec_t tv[16];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Counts edges until motion is nonzero, starting from 'start'; bounded by 'limit'.
  task automatic wait_pulse(input int start, input int limit, output int n);
    n = start;
    do begin
      step();
      n++;
    end while (motion == 3'd0 && n < limit);
    if (motion == 3'd0) begin
      total++;
      bad++;
      $display("FAIL pulse_timeout got=%0d want=pulse", n);
    end
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    enable    = 1'b0;
    victory   = 1'b0;
    defeat    = 1'b0;
    can_left  = 1'b1;
    can_right = 1'b1;
    alive     = 32'hFFFF_FFFF;
    step();
    step();
  endtask

  initial begin
    int n;
    int nz;

    tv[0]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 21, 3'd2, 1'b1};
    tv[1]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 20, 3'd2, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 20, 3'd3, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 32'hFFFF_FFFF,  4, 3'd3, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 32'hFFFF_FFFF,  4, 3'd3, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 20, 3'd1, 1'b1};
    tv[6]  = '{1'b1, 1'b1, 32'hFFFF_FFF0, 20, 3'd1, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 32'hFFFF_FFF0, 12, 3'd1, 1'b1};
    tv[8]  = '{1'b1, 1'b1, 32'h0000_0001, 12, 3'd1, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 32'h0000_0001,  8, 3'd1, 1'b1};
    tv[10] = '{1'b0, 1'b1, 32'h0000_0001,  8, 3'd3, 1'b1};
    tv[11] = '{1'b0, 1'b1, 32'h0000_0001,  4, 3'd3, 1'b1};
    tv[12] = '{1'b0, 1'b1, 32'h0000_0001,  4, 3'd3, 1'b1};
    tv[13] = '{1'b1, 1'b1, 32'h0000_0001,  8, 3'd2, 1'b0};
    tv[14] = '{1'b1, 1'b1, 32'hFFFF_FFFF,  8, 3'd2, 1'b1};
    tv[15] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 20, 3'd2, 1'b0};

    do_reset();
    chk("rst_motion", int'(motion), 0);
    chk("rst_anim", int'(anim_frame), 0);
    chk("rst_halted", int'(halted), 0);

    // Main march / descent / speed-up sequence
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      can_left  = tv[i].can_l;
      can_right = tv[i].can_r;
      alive     = tv[i].alv;
      wait_pulse((i == 0) ? 0 : 1, tv[i].gap + 6, n);
      chk($sformatf("gap[%0d]", i), n, tv[i].gap);
      chk($sformatf("motion[%0d]", i), int'(motion), int'(tv[i].mot));
      chk($sformatf("anim[%0d]", i), int'(anim_frame), int'(tv[i].anim));
      step();
      chk($sformatf("width[%0d]", i), int'(motion), 0);
    end

    // Victory on a tick cycle: no pulse, sticky halt
    do_reset();
    reset  = 1'b0;
    enable = 1'b1;
    wait_pulse(0, 30, n);
    chk("vic_first", n, 21);
    for (int i = 0; i < 19; i++) step();
    chk("vic_pre_motion", int'(motion), 0);
    victory = 1'b1;
    step();
    chk("vic_motion", int'(motion), 0);
    chk("vic_halted", int'(halted), 1);
    victory = 1'b0;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (motion != 3'd0) nz++;
    end
    chk("halt_quiet", nz, 0);
    chk("halt_sticky", int'(halted), 1);
    reset = 1'b1;
    step();
    chk("halt_reset", int'(halted), 0);

    // Enable pause between descent pulses
    do_reset();
    reset     = 1'b0;
    can_right = 1'b0;
    enable    = 1'b1;
    wait_pulse(0, 30, n);
    chk("pause_d1_gap", n, 21);
    chk("pause_d1_mot", int'(motion), 3);
    enable = 1'b0;
    nz = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (motion != 3'd0) nz++;
    end
    chk("pause_quiet", nz, 0);
    enable = 1'b1;
    wait_pulse(10, 24, n);
    chk("pause_d2_gap", n, 14);
    chk("pause_d2_mot", int'(motion), 3);
    wait_pulse(0, 10, n);
    chk("pause_d3_gap", n, 4);
    chk("pause_d3_mot", int'(motion), 3);
    wait_pulse(0, 30, n);
    chk("pause_left_gap", n, 20);
    chk("pause_left_mot", int'(motion), 1);
    chk("pause_left_anim", int'(anim_frame), 1);

    // Reset in the middle of a descent
    do_reset();
    reset     = 1'b0;
    can_right = 1'b0;
    enable    = 1'b1;
    wait_pulse(0, 30, n);
    chk("mid_d1_mot", int'(motion), 3);
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_motion", int'(motion), 0);
    reset  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("mid_idle_motion", int'(motion), 0);
    can_right = 1'b1;
    enable    = 1'b1;
    wait_pulse(0, 30, n);
    chk("mid_restart_gap", n, 21);
    chk("mid_restart_mot", int'(motion), 2);
    chk("mid_restart_anim", int'(anim_frame), 1);

    // Defeat also halts
    defeat = 1'b1;
    step();
    chk("defeat_halted", int'(halted), 1);
    defeat = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
